// File: rtl/rule_cfg_master.sv
// Purpose : rule-bus initiator; turns host config commands into single-beat rule writes/reads
// Latency : write strobe 1 cycle after accept, response 2 cycles after accept (unverified write)
// Backpressure: one command in flight; o_cmd_ready low until the response is taken by i_rsp_ready
//
// Ports:
//   i_clk, i_rst                     clock, synchronous active-high reset
//   i_cmd_* / o_cmd_ready            command stream (write/verify/addr/wdata)
//   o_rule_wren/rden/addr/wdata      rule bus request side
//   i_rule_rdata_valid/i_rule_rdata  rule bus read return
//   o_rsp_* / i_rsp_ready            response stream (rdata + status: 0 ok, 1 mismatch, 2 timeout)
//   o_wr_cnt, o_err_cnt              saturating statistics
module rule_cfg_master #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_cmd_valid,
    output logic                  o_cmd_ready,
    input  logic                  i_cmd_write,
    input  logic                  i_cmd_verify,
    input  logic [ADDR_WIDTH-1:0] i_cmd_addr,
    input  logic [DATA_WIDTH-1:0] i_cmd_wdata,
    output logic                  o_rule_wren,
    output logic                  o_rule_rden,
    output logic [ADDR_WIDTH-1:0] o_rule_addr,
    output logic [DATA_WIDTH-1:0] o_rule_wdata,
    input  logic                  i_rule_rdata_valid,
    input  logic [DATA_WIDTH-1:0] i_rule_rdata,
    output logic                  o_rsp_valid,
    input  logic                  i_rsp_ready,
    output logic [DATA_WIDTH-1:0] o_rsp_rdata,
    output logic [1:0]            o_rsp_status,
    output logic [CNT_WIDTH-1:0]  o_wr_cnt,
    output logic [CNT_WIDTH-1:0]  o_err_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_RD_ISSUE,
        S_RD_WAIT,
        S_RESP
    } state_t;

    // Latched command; addr/wdata double as the rule-bus address/data registers,
    // so they naturally hold their last value between strobes.
    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
        logic                  verify;
    } cmd_t;

    localparam int             TW          = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0]  TMO_LAST    = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0]     ST_OK       = 2'd0;
    localparam logic [1:0]     ST_MISMATCH = 2'd1;
    localparam logic [1:0]     ST_TIMEOUT  = 2'd2;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    state_t                state_q,   state_d;
    cmd_t                  cmd_q,     cmd_d;
    logic [DATA_WIDTH-1:0] rdata_q,   rdata_d;
    logic [1:0]            status_q,  status_d;
    logic [TW-1:0]         tmo_q,     tmo_d;
    logic [CNT_WIDTH-1:0]  wr_cnt_q,  wr_cnt_d;
    logic [CNT_WIDTH-1:0]  err_cnt_q, err_cnt_d;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= S_IDLE;
            cmd_q     <= '0;
            rdata_q   <= '0;
            status_q  <= ST_OK;
            tmo_q     <= '0;
            wr_cnt_q  <= '0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            rdata_q   <= rdata_d;
            status_q  <= status_d;
            tmo_q     <= tmo_d;
            wr_cnt_q  <= wr_cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        rdata_d   = rdata_q;
        status_d  = status_q;
        tmo_d     = tmo_q;
        wr_cnt_d  = wr_cnt_q;
        err_cnt_d = err_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (i_cmd_valid) begin
                    cmd_d.addr   = i_cmd_addr;
                    // verify is meaningless for reads; drop it here so RD_WAIT only
                    // compares after a write
                    cmd_d.verify = i_cmd_write & i_cmd_verify;
                    if (i_cmd_write) begin
                        cmd_d.wdata = i_cmd_wdata;
                        state_d     = S_WRITE;
                    end else begin
                        state_d     = S_RD_ISSUE;
                    end
                end
            end
            S_WRITE: begin
                wr_cnt_d = sat_inc(wr_cnt_q);
                if (cmd_q.verify) begin
                    state_d = S_RD_ISSUE;
                end else begin
                    rdata_d  = '0;
                    status_d = ST_OK;
                    state_d  = S_RESP;
                end
            end
            S_RD_ISSUE: begin
                tmo_d   = '0;
                state_d = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                // returned data takes priority over a timeout expiring in the same cycle
                if (i_rule_rdata_valid) begin
                    rdata_d = i_rule_rdata;
                    state_d = S_RESP;
                    if (cmd_q.verify && (i_rule_rdata != cmd_q.wdata)) begin
                        status_d  = ST_MISMATCH;
                        err_cnt_d = sat_inc(err_cnt_q);
                    end else begin
                        status_d  = ST_OK;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    rdata_d   = '0;
                    status_d  = ST_TIMEOUT;
                    err_cnt_d = sat_inc(err_cnt_q);
                    state_d   = S_RESP;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            S_RESP: begin
                if (i_rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign o_cmd_ready  = (state_q == S_IDLE);
    assign o_rule_wren  = (state_q == S_WRITE);
    assign o_rule_rden  = (state_q == S_RD_ISSUE);
    assign o_rule_addr  = cmd_q.addr;
    assign o_rule_wdata = cmd_q.wdata;
    assign o_rsp_valid  = (state_q == S_RESP);
    assign o_rsp_rdata  = rdata_q;
    assign o_rsp_status = status_q;
    assign o_wr_cnt     = wr_cnt_q;
    assign o_err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_rule_cfg_master.sv
// Purpose : self-checking bench for rule_cfg_master (transaction model + per-cycle compare)
// Latency : n/a
// Backpressure: drives i_rsp_ready low for random/fixed hold periods
module tb_rule_cfg_master;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int TMO  = 16;
    localparam int CW   = 8;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          i_rst;
    logic          i_cmd_valid;
    logic          o_cmd_ready;
    logic          i_cmd_write;
    logic          i_cmd_verify;
    logic [AW-1:0] i_cmd_addr;
    logic [DW-1:0] i_cmd_wdata;
    logic          o_rule_wren;
    logic          o_rule_rden;
    logic [AW-1:0] o_rule_addr;
    logic [DW-1:0] o_rule_wdata;
    logic          i_rule_rdata_valid;
    logic [DW-1:0] i_rule_rdata;
    logic          o_rsp_valid;
    logic          i_rsp_ready;
    logic [DW-1:0] o_rsp_rdata;
    logic [1:0]    o_rsp_status;
    logic [CW-1:0] o_wr_cnt;
    logic [CW-1:0] o_err_cnt;

    always #5 clk = ~clk;

    rule_cfg_master #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TMO),
        .CNT_WIDTH      (CW)
    ) dut (
        .i_clk              (clk),
        .i_rst              (i_rst),
        .i_cmd_valid        (i_cmd_valid),
        .o_cmd_ready        (o_cmd_ready),
        .i_cmd_write        (i_cmd_write),
        .i_cmd_verify       (i_cmd_verify),
        .i_cmd_addr         (i_cmd_addr),
        .i_cmd_wdata        (i_cmd_wdata),
        .o_rule_wren        (o_rule_wren),
        .o_rule_rden        (o_rule_rden),
        .o_rule_addr        (o_rule_addr),
        .o_rule_wdata       (o_rule_wdata),
        .i_rule_rdata_valid (i_rule_rdata_valid),
        .i_rule_rdata       (i_rule_rdata),
        .o_rsp_valid        (o_rsp_valid),
        .i_rsp_ready        (i_rsp_ready),
        .o_rsp_rdata        (o_rsp_rdata),
        .o_rsp_status       (o_rsp_status),
        .o_wr_cnt           (o_wr_cnt),
        .o_err_cnt          (o_err_cnt)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected per-cycle view, maintained by the stimulus process from the latency rules
    bit            chk_en       = 1'b0;
    bit            chk_ready_en = 1'b0;
    logic          exp_ready, exp_wren, exp_rden, exp_rsp;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_wdata, exp_rdata;
    logic [1:0]    exp_status;
    int            m_wr  = 0;
    int            m_err = 0;

    // Values the DUT showed at notable points of the last command, for literal pins
    logic [AW-1:0] seen_waddr;
    logic [DW-1:0] seen_wdata, seen_rdata;
    logic [1:0]    seen_status;
    int            seen_lat;

    always @(negedge clk) begin
        if (chk_en) begin
            if (chk_ready_en) chk("cmd_ready", o_cmd_ready, exp_ready);
            chk("rule_wren", o_rule_wren, exp_wren);
            chk("rule_rden", o_rule_rden, exp_rden);
            chk("rule_addr", o_rule_addr, exp_addr);
            if (exp_wren) chk("rule_wdata", o_rule_wdata, exp_wdata);
            chk("rsp_valid", o_rsp_valid, exp_rsp);
            if (exp_rsp) begin
                chk("rsp_rdata", o_rsp_rdata, exp_rdata);
                chk("rsp_status", o_rsp_status, exp_status);
            end
            chk("wr_cnt", o_wr_cnt, m_wr);
            chk("err_cnt", o_err_cnt, m_err);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    function automatic int sat(input int v);
        return (v < CMAX) ? v + 1 : v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle_exp();
        exp_ready = 1'b1;
        exp_wren  = 1'b0;
        exp_rden  = 1'b0;
        exp_rsp   = 1'b0;
    endtask

    // Noise on inputs the DUT must ignore in the current state
    task automatic stray();
        i_rule_rdata_valid = 1'($urandom_range(0, 1));
        i_rule_rdata       = $urandom;
        i_rsp_ready        = 1'($urandom_range(0, 1));
    endtask

    task automatic busy_cmd();
        i_cmd_valid  = 1'($urandom_range(0, 1));
        i_cmd_write  = 1'($urandom_range(0, 1));
        i_cmd_verify = 1'($urandom_range(0, 1));
        i_cmd_addr   = $urandom;
        i_cmd_wdata  = $urandom;
    endtask

    task automatic do_reset(input int n);
        i_rst              = 1'b1;
        i_rule_rdata_valid = 1'b1;
        i_cmd_valid        = 1'b0;
        step();
        m_wr = 0; m_err = 0; exp_addr = '0;
        set_idle_exp();
        exp_ready    = 1'b0;
        chk_ready_en = 1'b0;
        chk_en       = 1'b1;
        repeat (n - 1) begin
            stray();
            step();
        end
        i_rst        = 1'b0;
        set_idle_exp();
        chk_ready_en = 1'b1;
        i_rule_rdata_valid = 1'b0;
        i_rsp_ready        = 1'b0;
        chk("ready_after_reset", o_cmd_ready, 1'b1);
    endtask

    // One command. k = RD_WAIT cycle (1-based) in which rdata_valid is returned;
    // 0 or > TMO means never. hold = cycles rsp_ready is held low in RESP.
    task automatic do_cmd(input bit wr, input bit vf, input logic [AW-1:0] a,
                          input logic [DW-1:0] wd, input int k, input logic [DW-1:0] rd,
                          input int hold, input int gap);
        int cyc;
        bit got;
        bit do_vf;
        do_vf = wr && vf;
        repeat (gap) begin
            set_idle_exp();
            i_cmd_valid = 1'b0;
            stray();
            step();
        end
        set_idle_exp();
        i_cmd_valid  = 1'b1;
        i_cmd_write  = wr;
        i_cmd_verify = vf;
        i_cmd_addr   = a;
        i_cmd_wdata  = wd;
        stray();
        step();
        cyc       = 1;
        exp_ready = 1'b0;
        exp_addr  = a;
        if (wr) begin
            exp_wren   = 1'b1;
            exp_wdata  = wd;
            seen_waddr = o_rule_addr;
            seen_wdata = o_rule_wdata;
            busy_cmd(); stray();
            step(); cyc++;
            m_wr     = sat(m_wr);
            exp_wren = 1'b0;
        end
        if (!wr || do_vf) begin
            exp_rden = 1'b1;
            busy_cmd(); stray();
            step(); cyc++;
            exp_rden = 1'b0;
            got = 1'b0;
            for (int j = 1; j <= TMO && !got; j++) begin
                busy_cmd();
                i_rsp_ready = 1'($urandom_range(0, 1));
                if (j == k) begin
                    i_rule_rdata_valid = 1'b1;
                    i_rule_rdata       = rd;
                    got                = 1'b1;
                end else begin
                    i_rule_rdata_valid = 1'b0;
                    i_rule_rdata       = $urandom;
                end
                step(); cyc++;
            end
            if (got) begin
                exp_rdata  = rd;
                exp_status = (do_vf && rd != wd) ? 2'd1 : 2'd0;
            end else begin
                exp_rdata  = '0;
                exp_status = 2'd2;
            end
            if (exp_status != 2'd0) m_err = sat(m_err);
        end else begin
            exp_rdata  = '0;
            exp_status = 2'd0;
        end
        exp_rsp     = 1'b1;
        seen_lat    = cyc;
        seen_status = o_rsp_status;
        seen_rdata  = o_rsp_rdata;
        for (int h = 0; h < hold; h++) begin
            busy_cmd(); stray();
            i_rsp_ready = 1'b0;
            step();
        end
        busy_cmd(); stray();
        i_rsp_ready = 1'b1;
        step();
        set_idle_exp();
        i_cmd_valid = 1'b0;
        i_rsp_ready = 1'b0;
        i_rule_rdata_valid = 1'b0;
    endtask

    initial begin
        i_rst = 1'b1; i_cmd_valid = 1'b0; i_cmd_write = 1'b0; i_cmd_verify = 1'b0;
        i_cmd_addr = '0; i_cmd_wdata = '0; i_rule_rdata_valid = 1'b0; i_rule_rdata = '0;
        i_rsp_ready = 1'b0;
        exp_addr = '0; exp_wdata = '0; exp_rdata = '0; exp_status = '0;
        set_idle_exp();

        do_reset(3);

        // plain write
        do_cmd(1'b1, 1'b0, 32'h400, 32'd6, 0, 32'd0, 0, 0);
        chk("pw_waddr", seen_waddr, 32'h400);
        chk("pw_wdata", seen_wdata, 32'd6);
        chk("pw_lat", seen_lat, 2);
        chk("pw_status", seen_status, 2'd0);
        chk("pw_rdata", seen_rdata, 32'd0);
        chk("pw_wr_cnt", o_wr_cnt, 8'd1);

        // verified write, matching readback two cycles after rden
        do_cmd(1'b1, 1'b1, 32'h203, 32'h0C, 2, 32'h0C, 0, 1);
        chk("vw_lat", seen_lat, 5);
        chk("vw_status", seen_status, 2'd0);
        chk("vw_rdata", seen_rdata, 32'h0C);

        // verified write, mismatch
        do_cmd(1'b1, 1'b1, 32'h203, 32'h0C, 2, 32'h0D, 0, 0);
        chk("vm_status", seen_status, 2'd1);
        chk("vm_rdata", seen_rdata, 32'h0D);
        chk("vm_err_cnt", o_err_cnt, 8'd1);

        // read timeout, then data arriving on the last wait cycle
        do_cmd(1'b0, 1'b0, 32'h500, 32'd0, 0, 32'd0, 0, 0);
        chk("to_lat", seen_lat, 18);
        chk("to_status", seen_status, 2'd2);
        chk("to_rdata", seen_rdata, 32'd0);
        chk("to_err_cnt", o_err_cnt, 8'd2);
        do_cmd(1'b0, 1'b0, 32'h500, 32'd0, 16, 32'hA5A5_0001, 0, 0);
        chk("tl_lat", seen_lat, 18);
        chk("tl_status", seen_status, 2'd0);
        chk("tl_rdata", seen_rdata, 32'hA5A5_0001);

        // response backpressure with stray rdata_valid in RESP
        do_cmd(1'b0, 1'b0, 32'h0040, 32'd0, 3, 32'h1234_5678, 5, 0);

        // randomized commands
        for (int n = 0; n < 150; n++) begin
            logic [DW-1:0] wd;
            wd = $urandom;
            do_cmd(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, wd,
                   $urandom_range(1, 20), ($urandom_range(0, 1) != 0) ? wd : DW'($urandom),
                   $urandom_range(0, 3), $urandom_range(0, 2));
        end

        // reset while a read is pending
        set_idle_exp();
        i_cmd_valid = 1'b1; i_cmd_write = 1'b0; i_cmd_verify = 1'b0;
        i_cmd_addr = 32'h123; i_cmd_wdata = 32'd0;
        step();
        i_cmd_valid = 1'b0; exp_ready = 1'b0; exp_addr = 32'h123; exp_rden = 1'b1;
        step();
        exp_rden = 1'b0; i_rule_rdata_valid = 1'b0;
        step();
        step();
        do_reset(3);
        repeat (3) begin
            set_idle_exp();
            i_cmd_valid = 1'b0;
            stray();
            chk("abort_no_rsp", o_rsp_valid, 1'b0);
            step();
        end
        i_rule_rdata_valid = 1'b0;
        i_rsp_ready        = 1'b0;

        // back-to-back unverified writes with rsp_ready high; counter saturation
        for (int n = 0; n < 300; n++) begin
            do_cmd(1'b1, 1'b0, AW'(n), $urandom, 0, 32'd0, 0, 0);
        end
        chk("wr_cnt_sat", o_wr_cnt, 8'hFF);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
